// File: rtl/rca_load_return_if.sv
// Load-issue / load-return / grid-result bundle for the RCA load return path.
// master drives issue and return requests; slave is the tracking block.
interface rca_load_return_if #(
    parameter int unsigned GRID_NUM_ROWS = 8,
    parameter int unsigned XLEN          = 32,
    parameter int unsigned DEPTH         = 4
);
    localparam int unsigned ROW_W = (GRID_NUM_ROWS > 1) ? $clog2(GRID_NUM_ROWS) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                     issue_load;
    logic [ROW_W-1:0]         issue_row;
    logic                     issue_ready;
    logic                     load_complete;
    logic [XLEN-1:0]          load_data;
    logic [GRID_NUM_ROWS-1:0] grid_row_ready;
    logic [GRID_NUM_ROWS-1:0] grid_result_valid;
    logic [XLEN-1:0]          grid_result_data;
    logic [CNT_W-1:0]         outstanding;
    logic                     idle;
    logic                     error_orphan;

    modport master (
        output issue_load, issue_row, load_complete, load_data, grid_row_ready,
        input  issue_ready, grid_result_valid, grid_result_data, outstanding, idle, error_orphan
    );

    modport slave (
        input  issue_load, issue_row, load_complete, load_data, grid_row_ready,
        output issue_ready, grid_result_valid, grid_result_data, outstanding, idle, error_orphan
    );
endinterface

// File: rtl/rca_load_return.sv
// Pairs in-order LSU load returns with the grid rows that issued them and
// delivers each result as a registered one-hot strobe to its row.
module rca_load_return #(
    parameter int unsigned GRID_NUM_ROWS = 8,
    parameter int unsigned XLEN          = 32,
    parameter int unsigned DEPTH         = 4
) (
    input logic              clk,
    input logic              rst,
    rca_load_return_if.slave bus
);
    localparam int unsigned ROW_W = (GRID_NUM_ROWS > 1) ? $clog2(GRID_NUM_ROWS) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ROW_W-1:0]         track_mem [DEPTH];
    logic [XLEN-1:0]          res_mem   [DEPTH];

    logic [PTR_W-1:0]         track_wr_q, track_wr_d, track_rd_q, track_rd_d;
    logic [PTR_W-1:0]         res_wr_q, res_wr_d, res_rd_q, res_rd_d;
    logic [CNT_W-1:0]         track_cnt_q, track_cnt_d, res_cnt_q, res_cnt_d;
    logic [GRID_NUM_ROWS-1:0] valid_q, valid_d;
    logic [XLEN-1:0]          data_q, data_d;
    logic                     orphan_q, orphan_d;

    logic                     track_full;
    logic                     track_push, res_push, deliver, orphan_hit;
    logic [ROW_W-1:0]         track_head;
    logic [XLEN-1:0]          res_head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        track_full = (track_cnt_q == CNT_W'(DEPTH));
        track_head = track_mem[track_rd_q];
        res_head   = res_mem[res_rd_q];

        track_push = bus.issue_load && !track_full;
        // Orphan test uses occupancies before this cycle's pops: a return is
        // only legal while some tracked load still lacks a buffered result.
        orphan_hit = bus.load_complete && (res_cnt_q == track_cnt_q);
        res_push   = bus.load_complete && !orphan_hit;
        deliver    = (track_cnt_q != '0) && (res_cnt_q != '0) && bus.grid_row_ready[track_head];

        track_wr_d  = track_push ? ptr_inc(track_wr_q) : track_wr_q;
        track_rd_d  = deliver    ? ptr_inc(track_rd_q) : track_rd_q;
        res_wr_d    = res_push   ? ptr_inc(res_wr_q)   : res_wr_q;
        res_rd_d    = deliver    ? ptr_inc(res_rd_q)   : res_rd_q;
        track_cnt_d = track_cnt_q + CNT_W'(track_push) - CNT_W'(deliver);
        res_cnt_d   = res_cnt_q + CNT_W'(res_push) - CNT_W'(deliver);

        valid_d  = deliver ? (GRID_NUM_ROWS'(1) << track_head) : '0;
        data_d   = deliver ? res_head : data_q;
        orphan_d = orphan_q | orphan_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            track_wr_q  <= '0;
            track_rd_q  <= '0;
            res_wr_q    <= '0;
            res_rd_q    <= '0;
            track_cnt_q <= '0;
            res_cnt_q   <= '0;
            valid_q     <= '0;
            data_q      <= '0;
            orphan_q    <= 1'b0;
        end else begin
            track_wr_q  <= track_wr_d;
            track_rd_q  <= track_rd_d;
            res_wr_q    <= res_wr_d;
            res_rd_q    <= res_rd_d;
            track_cnt_q <= track_cnt_d;
            res_cnt_q   <= res_cnt_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            orphan_q    <= orphan_d;
        end
    end

    always_ff @(posedge clk) begin
        if (track_push) track_mem[track_wr_q] <= bus.issue_row;
        if (res_push)   res_mem[res_wr_q]     <= bus.load_data;
    end

    assign bus.issue_ready       = !track_full;
    assign bus.grid_result_valid = valid_q;
    assign bus.grid_result_data  = data_q;
    assign bus.outstanding       = track_cnt_q;
    assign bus.idle              = (track_cnt_q == '0) && (res_cnt_q == '0);
    assign bus.error_orphan      = orphan_q;
endmodule

// File: tb/tb_rca_load_return.sv
// Scenario bench for rca_load_return: a queue model predicts deliveries and a
// negedge monitor pops and compares every result strobe.
module tb_rca_load_return;
    localparam int unsigned ROWS = 8;
    localparam int unsigned XL   = 32;
    localparam int unsigned DP   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rca_load_return_if #(.GRID_NUM_ROWS(ROWS), .XLEN(XL), .DEPTH(DP)) bus ();
    rca_load_return #(.GRID_NUM_ROWS(ROWS), .XLEN(XL), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct packed {
        logic [7:0]  vld;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q [$];
    logic [2:0]  trk_m [$];
    logic [31:0] res_m [$];
    int          vectors     = 0;
    int          miscompares = 0;
    bit          mon_en      = 1'b0;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (mon_en && bus.grid_result_valid !== 8'h00) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL strobe_unexpected: got valid=%h data=%h, required no strobe",
                         bus.grid_result_valid, bus.grid_result_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.grid_result_valid, bus.grid_result_data} !== mon_e) begin
                    miscompares++;
                    $display("FAIL strobe_order: got valid=%h data=%h, required valid=%h data=%h",
                             bus.grid_result_valid, bus.grid_result_data, mon_e.vld, mon_e.data);
                end
            end
        end
    end

    task automatic drive(input logic il, input logic [2:0] row, input logic lc,
                         input logic [31:0] d, input logic [7:0] rdy);
        bus.issue_load     = il;
        bus.issue_row      = row;
        bus.load_complete  = lc;
        bus.load_data      = d;
        bus.grid_row_ready = rdy;
    endtask

    // Advance one clock, updating the reference queues from the applied inputs.
    task automatic step();
        bit          del, acc, orph, lc;
        logic [2:0]  r;
        logic [31:0] d;
        exp_t        e;
        del  = trk_m.size() > 0 && res_m.size() > 0 && bus.grid_row_ready[trk_m[0]] === 1'b1;
        acc  = bus.issue_load === 1'b1 && trk_m.size() < DP;
        lc   = bus.load_complete === 1'b1;
        orph = lc && res_m.size() == trk_m.size();
        r    = bus.issue_row;
        d    = bus.load_data;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            trk_m.delete();
            res_m.delete();
        end else begin
            if (del) begin
                e.vld  = 8'(1) << trk_m[0];
                e.data = res_m[0];
                exp_q.push_back(e);
                void'(trk_m.pop_front());
                void'(res_m.pop_front());
            end
            if (acc) trk_m.push_back(r);
            if (lc && !orph) res_m.push_back(d);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 3'd0, 1'b0, 32'h0, 8'hFF);
        step();
        step();
        rst    = 1'b0;
        mon_en = 1'b1;
        vectors++; if (bus.grid_result_valid !== 8'h00) begin miscompares++; $display("FAIL rst_valid: got %h, required 00", bus.grid_result_valid); end
        vectors++; if (bus.grid_result_data !== 32'h0) begin miscompares++; $display("FAIL rst_data: got %h, required 0", bus.grid_result_data); end
        vectors++; if (bus.outstanding !== 3'd0) begin miscompares++; $display("FAIL rst_outstanding: got %0d, required 0", bus.outstanding); end
        vectors++; if (bus.idle !== 1'b1) begin miscompares++; $display("FAIL rst_idle: got %b, required 1", bus.idle); end
        vectors++; if (bus.issue_ready !== 1'b1) begin miscompares++; $display("FAIL rst_issue_ready: got %b, required 1", bus.issue_ready); end
        vectors++; if (bus.error_orphan !== 1'b0) begin miscompares++; $display("FAIL rst_orphan: got %b, required 0", bus.error_orphan); end
    endtask

    task automatic test_single();
        drive(1'b1, 3'd3, 1'b0, 32'h0, 8'hFF); step();
        drive(1'b0, 3'd0, 1'b0, 32'h0, 8'hFF); step();
        drive(1'b0, 3'd0, 1'b1, 32'hDEADBEEF, 8'hFF); step();
        drive(1'b0, 3'd0, 1'b0, 32'h0, 8'hFF);
        vectors++; if (bus.grid_result_valid !== 8'h00) begin miscompares++; $display("FAIL single_early: got %h, required 00", bus.grid_result_valid); end
        step();
        vectors++; if (bus.grid_result_valid !== 8'h08) begin miscompares++; $display("FAIL single_valid: got %h, required 08", bus.grid_result_valid); end
        vectors++; if (bus.grid_result_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL single_data: got %h, required deadbeef", bus.grid_result_data); end
        vectors++; if (bus.outstanding !== 3'd0) begin miscompares++; $display("FAIL single_outstanding: got %0d, required 0", bus.outstanding); end
        vectors++; if (bus.idle !== 1'b1) begin miscompares++; $display("FAIL single_idle: got %b, required 1", bus.idle); end
        step();
        vectors++; if (bus.grid_result_valid !== 8'h00) begin miscompares++; $display("FAIL single_oneshot: got %h, required 00", bus.grid_result_valid); end
    endtask

    task automatic test_head_of_line();
        logic [7:0]  ev [3];
        logic [31:0] ed [3];
        ev = '{8'h02, 8'h20, 8'h04};
        ed = '{32'h1111AAAA, 32'h2222BBBB, 32'h3333CCCC};
        drive(1'b1, 3'd1, 1'b0, 32'h0, 8'hFD); step();
        drive(1'b1, 3'd5, 1'b0, 32'h0, 8'hFD); step();
        drive(1'b1, 3'd2, 1'b0, 32'h0, 8'hFD); step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 3'd0, 1'b1, ed[i], 8'hFD); step();
        end
        drive(1'b0, 3'd0, 1'b0, 32'h0, 8'hFD);
        for (int i = 0; i < 10; i++) begin
            step();
            vectors++; if (bus.grid_result_valid !== 8'h00) begin miscompares++; $display("FAIL hol_hold: cycle %0d got %h, required 00", i, bus.grid_result_valid); end
        end
        drive(1'b0, 3'd0, 1'b0, 32'h0, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (bus.grid_result_valid !== ev[i] || bus.grid_result_data !== ed[i]) begin
                miscompares++;
                $display("FAIL hol_release: slot %0d got valid=%h data=%h, required valid=%h data=%h",
                         i, bus.grid_result_valid, bus.grid_result_data, ev[i], ed[i]);
            end
        end
        step();
        vectors++; if (bus.grid_result_valid !== 8'h00 || bus.idle !== 1'b1) begin miscompares++; $display("FAIL hol_drain: got valid=%h idle=%b, required 00/1", bus.grid_result_valid, bus.idle); end
    endtask

    task automatic test_full();
        logic [2:0] rows [4];
        rows = '{3'd4, 3'd6, 3'd7, 3'd0};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, rows[i], 1'b0, 32'h0, 8'h00); step();
        end
        vectors++; if (bus.issue_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %b, required 0", bus.issue_ready); end
        vectors++; if (bus.outstanding !== 3'd4) begin miscompares++; $display("FAIL full_outstanding: got %0d, required 4", bus.outstanding); end
        drive(1'b1, 3'd1, 1'b0, 32'h0, 8'h00); step();
        vectors++; if (bus.outstanding !== 3'd4) begin miscompares++; $display("FAIL full_ignored: got %0d, required 4", bus.outstanding); end
        drive(1'b0, 3'd0, 1'b1, 32'h0F0F0004, 8'h00); step();
        drive(1'b0, 3'd0, 1'b0, 32'h0, 8'h10); step();
        vectors++; if (bus.issue_ready !== 1'b1) begin miscompares++; $display("FAIL full_reopen: got %b, required 1", bus.issue_ready); end
        vectors++; if (bus.outstanding !== 3'd3) begin miscompares++; $display("FAIL full_after_delivery: got %0d, required 3", bus.outstanding); end
        vectors++; if (bus.grid_result_valid !== 8'h10) begin miscompares++; $display("FAIL full_strobe: got %h, required 10", bus.grid_result_valid); end
        drive(1'b0, 3'd0, 1'b1, 32'h0F0F0006, 8'hFF); step();
        drive(1'b0, 3'd0, 1'b1, 32'h0F0F0007, 8'hFF); step();
        drive(1'b0, 3'd0, 1'b1, 32'h0F0F0000, 8'hFF); step();
        drive(1'b0, 3'd0, 1'b0, 32'h0, 8'hFF);
        repeat (3) step();
        vectors++; if (bus.outstanding !== 3'd0 || bus.idle !== 1'b1) begin miscompares++; $display("FAIL full_drain: got outstanding=%0d idle=%b, required 0/1", bus.outstanding, bus.idle); end
    endtask

    task automatic test_orphan();
        drive(1'b0, 3'd0, 1'b1, 32'hBAD00001, 8'hFF); step();
        drive(1'b0, 3'd0, 1'b0, 32'h0, 8'hFF);
        vectors++; if (bus.error_orphan !== 1'b1) begin miscompares++; $display("FAIL orphan_flag: got %b, required 1", bus.error_orphan); end
        vectors++; if (bus.idle !== 1'b1) begin miscompares++; $display("FAIL orphan_idle: got %b, required 1", bus.idle); end
        step();
        vectors++; if (bus.grid_result_valid !== 8'h00) begin miscompares++; $display("FAIL orphan_strobe: got %h, required 00", bus.grid_result_valid); end
        repeat (5) step();
        vectors++; if (bus.error_orphan !== 1'b1) begin miscompares++; $display("FAIL orphan_sticky: got %b, required 1", bus.error_orphan); end
        rst = 1'b1; step(); rst = 1'b0;
        vectors++; if (bus.error_orphan !== 1'b0) begin miscompares++; $display("FAIL orphan_clear: got %b, required 0", bus.error_orphan); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 3'd3, 1'b0, 32'h0, 8'h00); step();
        drive(1'b1, 3'd4, 1'b0, 32'h0, 8'h00); step();
        drive(1'b0, 3'd0, 1'b1, 32'h55555555, 8'h00); step();
        drive(1'b0, 3'd0, 1'b0, 32'h0, 8'h00);
        vectors++; if (bus.outstanding !== 3'd2 || bus.idle !== 1'b0) begin miscompares++; $display("FAIL midrst_pre: got outstanding=%0d idle=%b, required 2/0", bus.outstanding, bus.idle); end
        rst = 1'b1;
        drive(1'b0, 3'd0, 1'b0, 32'h0, 8'hFF); step();
        rst = 1'b0;
        vectors++; if (bus.outstanding !== 3'd0) begin miscompares++; $display("FAIL midrst_outstanding: got %0d, required 0", bus.outstanding); end
        vectors++; if (bus.idle !== 1'b1) begin miscompares++; $display("FAIL midrst_idle: got %b, required 1", bus.idle); end
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++; if (bus.grid_result_valid !== 8'h00) begin miscompares++; $display("FAIL midrst_strobe: cycle %0d got %h, required 00", i, bus.grid_result_valid); end
        end
        drive(1'b0, 3'd0, 1'b1, 32'h66666666, 8'hFF); step();
        drive(1'b0, 3'd0, 1'b0, 32'h0, 8'hFF);
        vectors++; if (bus.error_orphan !== 1'b1 || bus.idle !== 1'b1) begin miscompares++; $display("FAIL midrst_late: got orphan=%b idle=%b, required 1/1", bus.error_orphan, bus.idle); end
        rst = 1'b1; step(); rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 3'd6, 1'b0, 32'h0, 8'h00); step();
        drive(1'b1, 3'd7, 1'b0, 32'h0, 8'h00); step();
        drive(1'b0, 3'd0, 1'b1, 32'hD1D1D1D1, 8'h00); step();
        vectors++; if (bus.outstanding !== 3'd2) begin miscompares++; $display("FAIL b2b_setup: got %0d, required 2", bus.outstanding); end
        drive(1'b1, 3'd2, 1'b1, 32'hD2D2D2D2, 8'hFF); step();
        vectors++; if (bus.outstanding !== 3'd2) begin miscompares++; $display("FAIL b2b_outstanding: got %0d, required 2", bus.outstanding); end
        vectors++; if (bus.grid_result_valid !== 8'h40 || bus.grid_result_data !== 32'hD1D1D1D1) begin miscompares++; $display("FAIL b2b_first: got valid=%h data=%h, required 40/d1d1d1d1", bus.grid_result_valid, bus.grid_result_data); end
        drive(1'b0, 3'd0, 1'b1, 32'hD3D3D3D3, 8'hFF); step();
        vectors++; if (bus.grid_result_valid !== 8'h80 || bus.grid_result_data !== 32'hD2D2D2D2) begin miscompares++; $display("FAIL b2b_second: got valid=%h data=%h, required 80/d2d2d2d2", bus.grid_result_valid, bus.grid_result_data); end
        drive(1'b0, 3'd0, 1'b0, 32'h0, 8'hFF); step();
        vectors++; if (bus.grid_result_valid !== 8'h04 || bus.grid_result_data !== 32'hD3D3D3D3) begin miscompares++; $display("FAIL b2b_third: got valid=%h data=%h, required 04/d3d3d3d3", bus.grid_result_valid, bus.grid_result_data); end
        step();
        vectors++; if (bus.outstanding !== 3'd0 || bus.idle !== 1'b1) begin miscompares++; $display("FAIL b2b_drain: got outstanding=%0d idle=%b, required 0/1", bus.outstanding, bus.idle); end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 3'd0, 1'b0, 32'h0, 8'hFF);
        test_reset();
        test_single();
        test_head_of_line();
        test_full();
        test_orphan();
        test_reset_mid();
        test_back_to_back();
        repeat (2) step();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drained: got %0d pending strobes, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
